// File: rtl/mult_operand_feeder.sv
// Operand-pair feeder for the block multiplier: 8-deep FIFO plus one output stage, metering BLOCK_LEN issues per block.
// Push-to-EN_mult latency 2 cycles, 1 pair/cycle sustained; in_ready is a flop (fifo_count < DEPTH), independent of RDY_mult.
module mult_operand_feeder #(
  parameter int WIDTH_IN      = 16,
  parameter int FIFO_LOGDEPTH = 3,
  parameter int LOGDEPTH      = 6,
  parameter int BLOCK_LEN     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_IN-1:0]      in_a,
  input  logic [WIDTH_IN-1:0]      in_b,
  input  logic                     flush,
  input  logic                     block_release,
  output logic                     EN_mult,
  output logic [WIDTH_IN-1:0]      mult_input0,
  output logic [WIDTH_IN-1:0]      mult_input1,
  input  logic                     RDY_mult,
  output logic                     block_done,
  output logic [LOGDEPTH:0]        issue_count,
  output logic [FIFO_LOGDEPTH:0]   fifo_count
);

  localparam int DEPTH     = 1 << FIFO_LOGDEPTH;
  localparam int BLOCK_M1  = BLOCK_LEN - 1;
  localparam logic [LOGDEPTH:0] BLOCK_LAST = BLOCK_M1[LOGDEPTH:0];

  typedef struct packed {
    logic [WIDTH_IN-1:0] a;
    logic [WIDTH_IN-1:0] b;
  } pair_t;

  typedef enum logic {ISSUE = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state_q, state_d;
  pair_t                    mem [DEPTH];
  pair_t                    stage_dat;
  logic                     stage_vld;
  logic [FIFO_LOGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOGDEPTH:0]   count_q, count_d;
  logic [LOGDEPTH:0]        issue_count_q, issue_count_d;
  logic                     block_done_q, block_done_d;
  logic                     in_ready_q;
  logic                     push, pop, handshake, last_issue, release_now, can_load;

  assign push        = in_valid && in_ready_q && !flush;
  assign handshake   = EN_mult && RDY_mult;
  assign last_issue  = handshake && (issue_count_q == BLOCK_LAST);
  assign release_now = (state_q == HOLD) && block_release;
  // A load is blocked once the pair in flight is the last one of the block.
  assign can_load    = ((state_q == ISSUE) && !last_issue) || release_now;
  assign pop         = !flush && (count_q != '0) && (!stage_vld || handshake) && can_load;

  assign in_ready    = in_ready_q;
  assign EN_mult     = stage_vld && (state_q == ISSUE);
  assign mult_input0 = stage_dat.a;
  assign mult_input1 = stage_dat.b;
  assign block_done  = block_done_q;
  assign issue_count = issue_count_q;
  assign fifo_count  = count_q;

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= pair_t'({in_a, in_b});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      // count never exceeds DEPTH, so the MSB alone means full.
      in_ready_q <= !count_d[FIFO_LOGDEPTH];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld <= 1'b0;
      stage_dat <= '0;
    end else if (flush) begin
      stage_vld <= 1'b0;
    end else if (pop) begin
      stage_vld <= 1'b1;
      stage_dat <= mem[rd_ptr];
    end else if (handshake) begin
      stage_vld <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    issue_count_d = issue_count_q;
    block_done_d  = 1'b0;
    if (flush) begin
      state_d       = ISSUE;
      issue_count_d = '0;
    end else begin
      case (state_q)
        ISSUE: begin
          if (handshake)
            issue_count_d = issue_count_q + 1'b1;
          if (last_issue) begin
            state_d      = HOLD;
            block_done_d = 1'b1;
          end
        end
        HOLD: begin
          if (block_release) begin
            state_d       = ISSUE;
            issue_count_d = '0;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ISSUE;
      issue_count_q <= '0;
      block_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_count_q <= issue_count_d;
      block_done_q  <= block_done_d;
    end
  end

endmodule

// File: doc/mult_operand_feeder.md
Name: mult_operand_feeder

Overview:
- Upstream stage of the 16x16 block multiplier.
- Accepts a stream of operand pairs through a valid/ready interface and buffers them in a small FIFO.
- Presents pairs to the multiplier on EN_mult/mult_input0/mult_input1 while honouring RDY_mult.
- Meters exactly BLOCK_LEN issues per memory block, then holds until software or the block reader releases it.

Parameters:
- WIDTH_IN, 16, operand width; matches the multiplier inputs.
- FIFO_LOGDEPTH, 3, log2 of the operand FIFO depth (DEPTH = 8).
- LOGDEPTH, 6, log2 of the multiplier memory depth.
- BLOCK_LEN, 64, issues per block; must be ≤ 2^LOGDEPTH and ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (assert = 0).
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  WIDTH_IN  operand A.
- in_b  input  WIDTH_IN  operand B.
- flush  input  1  synchronous clear of FIFO, output stage, counter and state.
- block_release  input  1  one-cycle pulse: leave HOLD, start next block.
- EN_mult  output  1  pair on mult_input0/1 is valid.
- mult_input0  output  WIDTH_IN  operand A to multiplier.
- mult_input1  output  WIDTH_IN  operand B to multiplier.
- RDY_mult  input  1  multiplier accepts a pair this cycle.
- block_done  output  1  one-cycle pulse when the BLOCK_LEN-th issue completes.
- issue_count  output  LOGDEPTH+1  issues completed in the current block.
- fifo_count  output  FIFO_LOGDEPTH+1  entries in the FIFO (output stage excluded).

Behaviour:
- Reset (rst=0, async):
  - in_ready=0 while reset is asserted; EN_mult=0; mult_input0/1=0; block_done=0; issue_count=0; fifo_count=0; state=ISSUE.
  - in_ready becomes 1 on the first edge after deassertion.
  - Reset mid-block discards all buffered and presented pairs.
- Push:
  - A pair is accepted on an edge where in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH), a registered/flop-derived signal with no combinational path from RDY_mult.
  - When full, a same-cycle pop does not enable a push.
- FIFO: circular buffer, pointers wrap modulo DEPTH, first-in first-out order preserved.
- Output stage (one register):
  - Holds the pair driven on mult_input0/1; EN_mult=1 when the stage is occupied and state=ISSUE.
  - Issue handshake = EN_mult && RDY_mult at a clock edge.
  - The stage loads from the FIFO head when it is empty, or on a handshake, provided the FIFO is non-empty and the issue would not exceed BLOCK_LEN.
  - Otherwise it empties on a handshake.
  - While EN_mult=1 && RDY_mult=0, mult_input0/1 stay stable.
- Latency and throughput:
  - A pair pushed into an empty FIFO with an empty stage appears on EN_mult 2 cycles after the push edge.
  - Sustained throughput is 1 pair/cycle.
- State machine:
  - ISSUE: each handshake increments issue_count. When the handshake makes issue_count == BLOCK_LEN, then:
    - block_done pulses for 1 cycle;
    - state moves to HOLD;
    - no further stage load happens for that block.
  - HOLD: EN_mult=0; the FIFO still accepts pushes; issue_count holds at BLOCK_LEN.
  - HOLD on block_release=1: state moves to ISSUE, issue_count resets to 0, the stage may load on the same edge, and EN_mult can rise on the next cycle.
  - block_release in ISSUE is ignored.
- flush:
  - Synchronous and highest priority.
  - Empties the FIFO and the stage, sets issue_count=0, state=ISSUE and EN_mult=0 on the next cycle.
  - A push on the flush cycle is dropped.
  - block_done is suppressed on the flush edge.
- Simultaneous events:
  - Push plus pop in the same cycle leaves fifo_count unchanged.
  - A handshake completing the block in the same cycle as block_release: the release is ignored; HOLD is entered.
- RDY_mult is treated as a pure per-cycle acceptance; the feeder never assumes acceptance without it.

Test Plan:
- Reset and basic issue:
  - Stimulus: release rst, push (3,5), RDY_mult=1.
  - Required: EN_mult=1 with mult_input0=3, mult_input1=5 exactly 2 cycles after the push; issue_count=1 after the handshake; fifo_count returns to 0.
- Backpressure:
  - Stimulus: RDY_mult=0, push 9 pairs back-to-back.
  - Required: 8 enter the FIFO plus 1 in the stage; in_ready=0 with fifo_count=8; the presented pair is stable.
  - Then: raise RDY_mult; the 9 pairs issue in order, one per cycle.
- Block boundary:
  - Stimulus: stream 70 pairs (i, i+1) with RDY_mult=1.
  - Required: exactly 64 handshakes; block_done pulses once after the 64th; EN_mult=0; issue_count=64; pairs 64–69 remain buffered.
  - Then: pulse block_release; pair (64,65) is issued next and issue_count restarts from 0.
- Flush mid-block:
  - Stimulus: after 10 issues, with 4 pairs queued, assert flush for 1 cycle.
  - Required: EN_mult=0, fifo_count=0 and issue_count=0 next cycle; a new push issues normally.
- Async reset mid-operation:
  - Stimulus: drop rst between clock edges while EN_mult=1.
  - Required: all outputs zero immediately, with no clock needed.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, RDY_mult=1, in_valid=1.
  - Required: pop occurs, push refused that cycle (in_ready=0); the push is accepted the following cycle.
